// File: rtl/nibble_serial_alu_seq.sv
// nibble_serial_alu_seq
// Operand sequencer that runs WIDTH-bit add/subtract through an external
// 4-bit adder, one nibble per cycle, least-significant nibble first.
// Subtraction is formed here as A + ~B + 1, so the adder always adds.
//
// Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
// DONE). busy is high for the N issue cycles. done pulses for one cycle
// when result and flags become valid. Both stay held until the next
// accepted start overwrites them.
module nibble_serial_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic [1:0]       add_mode,
    output logic             add_cin,
    input  logic [3:0]       add_sum,
    input  logic             add_cout
);

    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry_r;
    logic [KW-1:0]    k;

    logic             is_sub;
    logic             last_step;
    logic [WIDTH-1:0] next_result;

    assign is_sub    = (mode == 2'b01);
    assign last_step = (k == KW'(N - 1));

    // The adder is only ever asked to add; subtraction is pre-formed in op_b.
    assign add_mode = 2'b00;

    // Result as it will look after the current nibble sum is written back.
    always_comb begin
        next_result = result;
        next_result[4*k +: 4] = add_sum;
    end

    // Drive the adder with the current nibble while running, zero otherwise.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = op_a[4*k +: 4];
            add_b   = op_b[4*k +: 4];
            add_cin = carry_r;
        end
    end

    // Sequencer FSM: capture operands, step through nibbles, register flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_a     <= '0;
            op_b     <= '0;
            carry_r  <= 1'b0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a    <= a;
                        op_b    <= is_sub ? ~b : b;
                        carry_r <= is_sub ? 1'b1 : c_in;
                        k       <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    result  <= next_result;
                    carry_r <= add_cout;
                    if (last_step) begin
                        k        <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                        // Flags come from the final nibble as it is written.
                        c_out    <= add_cout;
                        zero     <= (next_result == '0);
                        overflow <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                    (add_sum[3] != op_a[WIDTH-1]);
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_alu_seq.sv
// Testbench for nibble_serial_alu_seq (WIDTH=16) with a behavioural
// 4-bit adder attached to the add_* ports.
module tb_nibble_serial_alu_seq;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;
    logic             zero;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic [1:0]       add_mode;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

    int errors = 0;
    int checks = 0;

    // Captured per run by launch()
    int               lat;
    int               busy_cnt;
    logic [3:0]       cap_b   [8];
    logic             cap_cin [8];
    logic             mode_bad;
    logic [WIDTH-1:0] cap_res1;

    nibble_serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_mode (add_mode),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Behavioural 4-bit adder
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation and records what the sequencer did until done.
    // poke > 0: at that cycle pulse start with a different operand while busy.
    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic [1:0] tm, input logic tc, input int poke);
        a = ta; b = tb; mode = tm; c_in = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cnt = 0; mode_bad = 1'b0; cap_res1 = result;
        for (int i = 0; i < 8; i++) begin cap_b[i] = 4'h0; cap_cin[i] = 1'b0; end
        for (int c = 1; c <= 20; c++) begin
            if (busy && busy_cnt < 8) begin
                cap_b[busy_cnt]   = add_b;
                cap_cin[busy_cnt] = add_cin;
                busy_cnt++;
            end
            if (add_mode !== 2'b00) mode_bad = 1'b1;
            if (done) begin lat = c; break; end
            if (c == poke) begin
                start = 1'b1; a = 16'hAAAA; b = 16'h5555; mode = 2'b00; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; mode = 2'b00; c_in = 1'b0;
        #3;
        checks++;
        if ({busy, done, c_out, overflow, zero, add_cin} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, c_out, overflow, zero, add_cin});
        end
        checks++;
        if ({result, add_a, add_b, add_mode} !== 26'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", {result, add_a, add_b, add_mode});
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: got busy/done %b expected 00", {busy, done});
        end
    endtask

    task automatic test_add;
        launch(16'h1234, 16'h0FCD, 2'b00, 1'b0, 0);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d expected 5", lat); end
        checks++;
        if (busy_cnt !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d expected 4", busy_cnt); end
        checks++;
        if (result !== 16'h2201) begin errors++; $display("FAIL add_result: got %h expected 2201", result); end
        checks++;
        if ({c_out, overflow, zero} !== 3'b000) begin
            errors++; $display("FAIL add_flags: got %b expected 000", {c_out, overflow, zero});
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00 || result !== 16'h2201) begin
            errors++; $display("FAIL add_hold: got done/busy %b result %h expected 00 2201", {done, busy}, result);
        end
    endtask

    task automatic test_add_carry;
        launch(16'hFFFF, 16'h0000, 2'b00, 1'b1, 0);
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL carry_result: got %h expected 0000", result); end
        checks++;
        if ({c_out, overflow, zero} !== 3'b101) begin
            errors++; $display("FAIL carry_flags: got %b expected 101", {c_out, overflow, zero});
        end
        checks++;
        if ({cap_cin[0], cap_cin[1], cap_cin[2], cap_cin[3]} !== 4'b1111) begin
            errors++; $display("FAIL carry_ripple: got %b expected 1111", {cap_cin[0], cap_cin[1], cap_cin[2], cap_cin[3]});
        end
    endtask

    task automatic test_sub;
        launch(16'h0005, 16'h0007, 2'b01, 1'b0, 0);
        checks++;
        if (result !== 16'hFFFE) begin errors++; $display("FAIL sub_result: got %h expected fffe", result); end
        checks++;
        if ({c_out, overflow, zero} !== 3'b000) begin
            errors++; $display("FAIL sub_flags: got %b expected 000", {c_out, overflow, zero});
        end
        checks++;
        if ({cap_b[0], cap_b[1], cap_b[2], cap_b[3]} !== 16'h8FFF) begin
            errors++; $display("FAIL sub_add_b: got %h expected 8fff", {cap_b[0], cap_b[1], cap_b[2], cap_b[3]});
        end
        checks++;
        if (mode_bad !== 1'b0) begin errors++; $display("FAIL sub_add_mode: got nonzero expected 00"); end
    endtask

    task automatic test_overflow;
        launch(16'h7FFF, 16'h0001, 2'b00, 1'b0, 0);
        checks++;
        if (result !== 16'h8000 || {c_out, overflow, zero} !== 3'b010) begin
            errors++; $display("FAIL ovf_add: got %h %b expected 8000 010", result, {c_out, overflow, zero});
        end
        launch(16'h8000, 16'h0001, 2'b01, 1'b0, 0);
        checks++;
        if (result !== 16'h7FFF || {c_out, overflow, zero} !== 3'b110) begin
            errors++; $display("FAIL ovf_sub: got %h %b expected 7fff 110", result, {c_out, overflow, zero});
        end
    endtask

    task automatic test_mode_1x;
        launch(16'h00FF, 16'h0001, 2'b10, 1'b1, 0);
        checks++;
        if (result !== 16'h0101 || {c_out, overflow, zero} !== 3'b000) begin
            errors++; $display("FAIL mode_1x: got %h %b expected 0101 000", result, {c_out, overflow, zero});
        end
    endtask

    task automatic test_busy_start;
        launch(16'h1111, 16'h2222, 2'b00, 1'b0, 2);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL busy_start_latency: got %0d expected 5", lat); end
        checks++;
        if (result !== 16'h3333) begin errors++; $display("FAIL busy_start_result: got %h expected 3333", result); end
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL busy_start_idle: got %b expected 00", {busy, done});
        end
    endtask

    task automatic test_back_to_back;
        launch(16'h0100, 16'h0200, 2'b00, 1'b0, 0);
        checks++;
        if (result !== 16'h0300) begin errors++; $display("FAIL b2b_first: got %h expected 0300", result); end
        // Start on the done cycle
        launch(16'h00F0, 16'h0010, 2'b01, 1'b0, 0);
        checks++;
        if (cap_res1 !== 16'h0300) begin errors++; $display("FAIL b2b_hold: got %h expected 0300", cap_res1); end
        checks++;
        if (lat !== 5 || busy_cnt !== 4) begin
            errors++; $display("FAIL b2b_latency: got %0d/%0d expected 5/4", lat, busy_cnt);
        end
        checks++;
        if (result !== 16'h00E0 || {c_out, overflow, zero} !== 3'b100) begin
            errors++; $display("FAIL b2b_second: got %h %b expected 00e0 100", result, {c_out, overflow, zero});
        end
    endtask

    task automatic test_reset_mid_run;
        logic saw_done;
        saw_done = 1'b0;
        a = 16'h4321; b = 16'h1111; mode = 2'b00; c_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, c_out, overflow, zero, add_cin} !== 6'b0 || {result, add_a, add_b, add_mode} !== 26'h0) begin
            errors++; $display("FAIL midrst_outputs: got %b %h expected all 0",
                               {busy, done, c_out, overflow, zero, add_cin}, {result, add_a, add_b, add_mode});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got done pulse expected none"); end
        launch(16'h0003, 16'h0004, 2'b00, 1'b0, 0);
        checks++;
        if (lat !== 5 || result !== 16'h0007) begin
            errors++; $display("FAIL midrst_recover: got lat %0d result %h expected 5 0007", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_carry();
        test_sub();
        test_overflow();
        test_mode_1x();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
